// File: rtl/wshb_rr_arbiter.sv
// Two-master / one-slave classic Wishbone arbiter for the SDRAM framebuffer port.
// Master 0 (VGA refill) and master 1 (pattern writer) share the slave with
// round-robin grants. Each master has an ack quota. Once the quota is used up,
// the grant is handed over on the next ack if the other master is waiting.
module wshb_rr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int QUOTA0 = 64,
  parameter int QUOTA1 = 16,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // master 0
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_dat_ms,
  input  logic [SEL_W-1:0]  m0_sel,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_dat_sm,
  // master 1
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_dat_ms,
  input  logic [SEL_W-1:0]  m1_sel,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_dat_sm,
  // slave
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_dat_ms,
  output logic [SEL_W-1:0]  s_sel,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_dat_sm,
  // status
  output logic [1:0]        gnt,
  output logic [15:0]       preempt_cnt
);

  localparam int CNT_MAX = (QUOTA0 > QUOTA1) ? QUOTA0 : QUOTA1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic               last_reg, last_next;      // 0 = master 0 owned last, 1 = master 1
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [15:0]        preempt_reg, preempt_next;
  logic [1:0]         gnt_reg;

  // Ack count including the ack arriving this cycle, used for the quota test.
  logic [31:0] cnt_plus;
  assign cnt_plus = 32'(cnt_reg) + 32'd1;

  logic quota0_hit, quota1_hit;
  assign quota0_hit = (cnt_plus >= 32'(QUOTA0));
  assign quota1_hit = (cnt_plus >= 32'(QUOTA1));

  logic [15:0] preempt_inc;
  assign preempt_inc = (preempt_reg == 16'hFFFF) ? preempt_reg : preempt_reg + 16'd1;

  // State, ownership history, counters and the registered grant vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_reg    <= 1'b1;
      cnt_reg     <= '0;
      preempt_reg <= '0;
      gnt_reg     <= 2'b00;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      cnt_reg     <= cnt_next;
      preempt_reg <= preempt_next;
      gnt_reg     <= {state_next == OWN1, state_next == OWN0};
    end
  end

  // Arbitration: pick the next owner, count acks, release and preempt.
  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    cnt_next     = cnt_reg;
    preempt_next = preempt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (m0_cyc && m1_cyc) state_next = last_reg ? OWN0 : OWN1;
        else if (m0_cyc)      state_next = OWN0;
        else if (m1_cyc)      state_next = OWN1;
      end
      OWN0: begin
        if (!m0_cyc) begin
          state_next = IDLE;
          last_next  = 1'b0;
          cnt_next   = '0;
        end else if (s_ack && quota0_hit && m1_cyc) begin
          state_next   = IDLE;
          last_next    = 1'b0;
          cnt_next     = '0;
          preempt_next = preempt_inc;
        end else if (s_ack && cnt_reg != CNT_SAT) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      OWN1: begin
        if (!m1_cyc) begin
          state_next = IDLE;
          last_next  = 1'b1;
          cnt_next   = '0;
        end else if (s_ack && quota1_hit && m0_cyc) begin
          state_next   = IDLE;
          last_next    = 1'b1;
          cnt_next     = '0;
          preempt_next = preempt_inc;
        end else if (s_ack && cnt_reg != CNT_SAT) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Bus steering from the registered owner; in IDLE the slave sees nothing
  // and any stray slave ack is swallowed.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state_reg)
      OWN0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        m0_ack   = s_ack;
      end
      OWN1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        m1_ack   = s_ack;
      end
      default: ;
    endcase
  end

  // Read data goes to both masters; only the acked one consumes it.
  assign m0_dat_sm   = s_dat_sm;
  assign m1_dat_sm   = s_dat_sm;
  assign gnt         = gnt_reg;
  assign preempt_cnt = preempt_reg;

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// Directed bench for wshb_rr_arbiter with QUOTA0 = 4 and QUOTA1 = 2.
// The slave model acks one cycle after it sees stb.
module tb_wshb_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we, m0_ack;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_ms, m0_dat_sm;
  logic [SW-1:0] m0_sel;
  logic          m1_cyc, m1_stb, m1_we, m1_ack;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_ms, m1_dat_sm;
  logic [SW-1:0] m1_sel;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_ms;
  logic [SW-1:0] s_sel;
  logic          s_ack = 1'b0;
  logic [DW-1:0] s_dat_sm;
  logic [1:0]    gnt;
  logic [15:0]   preempt_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wshb_rr_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .QUOTA0(4), .QUOTA1(2)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_ack(s_ack), .s_dat_sm(s_dat_sm),
    .gnt(gnt), .preempt_cnt(preempt_cnt)
  );

  // Slave: acknowledges one cycle after it sees a strobe.
  always @(posedge clk) s_ack <= s_cyc & s_stb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Contention cycles 1..16 after reset release (both masters hold cyc/stb).
  int exp_gnt [16] = '{1, 1, 1, 1, 1, 0, 2, 2, 2, 0, 1, 1, 1, 1, 1, 0};
  int exp_a0  [16] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
  int exp_a1  [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
  int exp_pc  [16] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3};

  int n0, n1, idx, cyc_used;
  logic [31:0] exp_adr;

  initial begin
    rst = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h0000_1000;
    m0_dat_ms = 32'h0; m0_sel = 4'hF;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h0000_2000;
    m1_dat_ms = 32'h5555_0000; m1_sel = 4'hF;
    s_dat_sm = 32'h0;

    // Reset with both masters requesting.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_sstb", s_stb, 0);
    chk("rst_preempt", preempt_cnt, 0);
    chk("rst_m0ack", m0_ack, 0);
    chk("rst_m1ack", m1_ack, 0);
    rst = 1'b0;

    // Contention: M0x4, IDLE, M1x2, IDLE, M0x4, IDLE.
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); #1;
      case (exp_gnt[c])
        1:       exp_adr = 32'h0000_1000;
        2:       exp_adr = 32'h0000_2000;
        default: exp_adr = 32'h0;
      endcase
      chk($sformatf("cont%0d_gnt", c + 1), gnt, exp_gnt[c]);
      chk($sformatf("cont%0d_m0ack", c + 1), m0_ack, exp_a0[c]);
      chk($sformatf("cont%0d_m1ack", c + 1), m1_ack, exp_a1[c]);
      chk($sformatf("cont%0d_preempt", c + 1), preempt_cnt, exp_pc[c]);
      chk($sformatf("cont%0d_scyc", c + 1), s_cyc, (exp_gnt[c] != 0) ? 1 : 0);
      chk($sformatf("cont%0d_sadr", c + 1), s_adr, exp_adr);
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;

    // Solo M1: ten writes, address/data follow M1, no preemption.
    @(negedge clk); #1;
    chk("solo_idle_gnt", gnt, 0);
    idx = 0; n0 = 0; n1 = 0; cyc_used = 0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    m1_adr = 32'h2000_0000; m1_dat_ms = 32'hA5A5_0000;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      @(negedge clk); #1;
      cyc_used++;
      if (gnt == 2'b10) begin
        chk("solo_adr", s_adr, m1_adr);
        chk("solo_dat", s_dat_ms, m1_dat_ms);
        chk("solo_we", s_we, 1);
      end
      if (m0_ack) n0++;
      if (m1_ack) begin
        n1++;
        idx++;
        m1_adr = 32'h2000_0000 + 32'(idx * 4);
        m1_dat_ms = 32'hA5A5_0000 + 32'(idx);
        if (idx == 10) begin
          m1_cyc = 1'b0; m1_stb = 1'b0;
        end
      end
    end
    chk("solo_m1acks", n1, 10);
    chk("solo_m0acks", n0, 0);
    chk("solo_cycles", cyc_used, 11);
    chk("solo_preempt", preempt_cnt, 3);

    // Late competitor: M0 takes 10 acks alone, then M1 raises cyc.
    @(negedge clk); #1;
    chk("late_idle_gnt", gnt, 0);
    n0 = 0; n1 = 0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h0000_3000;
    for (int c = 0; c < 40 && n0 < 10; c++) begin
      @(negedge clk); #1;
      if (m0_ack) n0++;
      if (m1_ack) n1++;
    end
    chk("late_m0acks", n0, 10);
    chk("late_m1acks", n1, 0);
    @(negedge clk);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h0000_4000;
    #1;
    chk("late_extra_m0ack", m0_ack, 1);
    chk("late_extra_gnt", gnt, 1);
    @(negedge clk); #1;
    chk("late_gap_gnt", gnt, 0);
    chk("late_gap_m0ack", m0_ack, 0);
    chk("late_gap_m1ack", m1_ack, 0);
    chk("late_gap_preempt", preempt_cnt, 4);
    @(negedge clk); #1;
    chk("late_m1_gnt", gnt, 2);
    chk("late_m1_first", m1_ack, 0);
    chk("late_m1_sadr", s_adr, 32'h0000_4000);
    @(negedge clk); #1;
    chk("late_m1_ack", m1_ack, 1);
    chk("late_m1_m0ack", m0_ack, 0);

    // Read data: M1 releases, M0 reads 0xDEADBEEF.
    m1_cyc = 1'b0; m1_stb = 1'b0;
    m0_we = 1'b0; s_dat_sm = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    chk("rd_idle_gnt", gnt, 0);
    chk("rd_idle_m1ack", m1_ack, 0);
    @(negedge clk); #1;
    chk("rd_gnt", gnt, 1);
    chk("rd_swe", s_we, 0);
    chk("rd_first_ack", m0_ack, 0);
    @(negedge clk); #1;
    chk("rd_m0ack", m0_ack, 1);
    chk("rd_m0dat", m0_dat_sm, 32'hDEAD_BEEF);
    chk("rd_m1dat", m1_dat_sm, 32'hDEAD_BEEF);
    chk("rd_m1ack", m1_ack, 0);

    // Reset during an M1 grant with an ack in flight.
    m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h0000_5000;
    @(negedge clk); #1;
    chk("rr_idle_gnt", gnt, 0);
    @(negedge clk); #1;
    chk("rr_own1_gnt", gnt, 2);
    chk("rr_own1_ack", m1_ack, 0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rr_gnt", gnt, 0);
    chk("rr_scyc", s_cyc, 0);
    chk("rr_m1ack_dropped", m1_ack, 0);
    chk("rr_m0ack", m0_ack, 0);
    chk("rr_preempt", preempt_cnt, 0);
    m0_cyc = 1'b1; m0_stb = 1'b1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rr_restart_gnt", gnt, 1);
    chk("rr_restart_m1ack", m1_ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
